// File: rtl/kamikaze_pkg.sv
// kamikaze_pkg
// Shared widths for the instruction prefetch path and the RV32C length rule.
//   XLEN     : address/data width of the fetch port
//   ILEN     : width of an instruction handed to decode
//   HALFWORD : realignment granule
//   is_compressed() : 16-bit encoding when opcode[1:0] != 2'b11
package kamikaze_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned HALFWORD = 16;

  function automatic logic is_compressed(input logic [1:0] opcode);
    return opcode != 2'b11;
  endfunction

endpackage

// File: rtl/kamikaze_fifo.sv
// kamikaze_fifo
// Generic synchronous FIFO with a one-entry look-ahead read port.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write an entry (ignored during flush)
//   pop        : drop the head entry
//   flush      : empty the FIFO, wins over push/pop
//   rdata      : head entry
//   rdata_next : entry behind the head (meaningful when count >= 2)
//   count      : current occupancy, 0..DEPTH
module kamikaze_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] rdata_next,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; count_q says which entries are meaningful.
  // A push+pop at full overwrites the slot being popped, which is safe
  // because the head is read combinationally in the same cycle.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata      = mem_q[rd_ptr_q];
  assign rdata_next = mem_q[rd_ptr_q + AW'(1)];
  assign count      = count_q;

  overflow_a : assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/kamikaze_prefetch_buffer.sv
// kamikaze_prefetch_buffer
// Instruction prefetch buffer and RV32C realigner between the instruction
// memory port and decode. Keeps up to DEPTH words buffered or in flight,
// hands out 16/32-bit instructions at halfword granularity and restarts on
// redirect, discarding responses to requests issued before the redirect.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   im_req_o, im_addr_o, im_gnt_i : word-aligned fetch request handshake
//   im_rvalid_i, im_data_i        : in-order fetch responses
//   redirect_i, redirect_pc_i     : flush and restart fetch
//   instr_o, is_compressed_instr_o, pc_o, instr_valid_o, instr_ready_i :
//                                   instruction handshake towards decode
module kamikaze_prefetch_buffer
  import kamikaze_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            im_req_o,
  output logic [XLEN-1:0] im_addr_o,
  input  logic            im_gnt_i,
  input  logic            im_rvalid_i,
  input  logic [XLEN-1:0] im_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [ILEN-1:0] instr_o,
  output logic            is_compressed_instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0]     fetch_addr_q;
  logic [XLEN-1:0]     pc_q;
  logic [CW-1:0]       outstanding_q;
  logic [CW-1:0]       discard_q;
  logic [CW-1:0]       occupancy;
  logic [XLEN-1:0]     head_word;
  logic [XLEN-1:0]     next_word;
  logic                grant;
  logic                push;
  logic                pop;
  logic                consume;
  logic                credit_ok;
  logic [HALFWORD-1:0] first_half;
  logic                first_is_c;
  logic                avail;
  logic [ILEN-1:0]     instr;
  logic                unused_next_hi;

  // Words still in flight count against capacity, so a response always
  // finds room in the FIFO even when decode is stalled.
  assign credit_ok = ({1'b0, occupancy} + {1'b0, outstanding_q} < (CW + 1)'(DEPTH))
                     && (outstanding_q < CW'(MAX_OUTSTANDING));
  assign im_req_o  = !rst_i && !redirect_i && credit_ok;
  assign im_addr_o = fetch_addr_q;
  assign grant     = im_req_o && im_gnt_i;

  // Responses that belong to pre-redirect requests never reach the FIFO.
  assign push = im_rvalid_i && !redirect_i && (discard_q == '0);

  kamikaze_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_i),
    .wdata      (im_data_i),
    .rdata      (head_word),
    .rdata_next (next_word),
    .count      (occupancy)
  );

  // Only the lower half of head+1 ever completes a spanning instruction.
  assign unused_next_hi = ^next_word[XLEN-1:HALFWORD];

  always_comb begin
    first_half = pc_q[1] ? head_word[31:16] : head_word[15:0];
    first_is_c = is_compressed(first_half[1:0]);
    instr      = head_word;
    avail      = occupancy != '0;
    if (first_is_c) begin
      instr = {16'h0000, first_half};
    end else if (pc_q[1]) begin
      // 32-bit instruction straddling two words.
      instr = {next_word[15:0], head_word[31:16]};
      avail = occupancy >= CW'(2);
    end
  end

  // Redirect wins over a same-cycle handshake: nothing is consumed.
  assign consume = avail && instr_ready_i && !redirect_i;
  // The head retires once its upper halfword has been used, either by a
  // full-word instruction at offset 0 or by anything starting at offset 2.
  assign pop     = consume && (pc_q[1] || !first_is_c);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_addr_q  <= RESET_PC & ~32'h3;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else if (redirect_i) begin
      // A response arriving in the redirect cycle is already dropped, so it
      // leaves both counters here.
      outstanding_q <= outstanding_q - CW'(im_rvalid_i);
      discard_q     <= outstanding_q - CW'(im_rvalid_i);
      fetch_addr_q  <= redirect_pc_i & ~32'h3;
      pc_q          <= redirect_pc_i & ~32'h1;
    end else begin
      outstanding_q <= outstanding_q + CW'(grant) - CW'(im_rvalid_i);
      if (im_rvalid_i && discard_q != '0) discard_q <= discard_q - CW'(1);
      if (grant)   fetch_addr_q <= fetch_addr_q + 32'd4;
      if (consume) pc_q <= pc_q + (first_is_c ? 32'd2 : 32'd4);
    end
  end

  assign instr_valid_o         = avail;
  assign instr_o               = avail ? instr : '0;
  assign is_compressed_instr_o = avail && first_is_c;
  assign pc_o                  = pc_q;

endmodule

// File: tb/tb_kamikaze_prefetch_buffer.sv
module tb_kamikaze_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i = 1'b0;
  logic        im_rvalid_i = 1'b0;
  logic [31:0] im_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_o;
  logic        is_compressed_instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;

  kamikaze_prefetch_buffer #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .im_req_o              (im_req_o),
    .im_addr_o             (im_addr_o),
    .im_gnt_i              (im_gnt_i),
    .im_rvalid_i           (im_rvalid_i),
    .im_data_i             (im_data_i),
    .redirect_i            (redirect_i),
    .redirect_pc_i         (redirect_pc_i),
    .instr_o               (instr_o),
    .is_compressed_instr_o (is_compressed_instr_o),
    .pc_o                  (pc_o),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i)
  );

  always #5 clk = ~clk;

  // ---------------- memory environment ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] mem_ovr [logic [31:0]];
  int          mem_mode = 0;
  int          base_lat = 0;
  int          max_lat = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_lat = 0;
  bit          rand_gnt = 0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_consumed = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          prev_hold = 0;
  logic [31:0] prev_pc, prev_instr;

  logic        s_req, s_valid, s_isc;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_ovr.exists(w)) return mem_ovr[w];
    if (mem_mode == 0) return {w[15:0], 16'h0013};
    return ((w ^ 32'h5bd1_e995) * 32'h9e37_79b1) ^ (w >> 13);
  endfunction

  // Reference model: the instruction stream as seen from a PC, built
  // directly from halfwords of memory.
  function automatic logic [15:0] half_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] instr_at(input logic [31:0] pc);
    logic [15:0] lo;
    lo = half_at(pc);
    if (lo[1:0] == 2'b11) return {half_at(pc + 32'd2), lo};
    return {16'h0000, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample settled outputs 2 ns
  // later, update the memory and stream models, then wait for the edge.
  task automatic cycle(input bit rdy, input bit redir = 1'b0, input logic [31:0] rpc = '0);
    int          lat;
    logic [31:0] exp_i;
    @(negedge clk);
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    im_gnt_i      = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      im_rvalid_i = 1'b1;
      im_data_i   = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      im_rvalid_i = 1'b0;
      im_data_i   = $urandom;
    end
    #2;
    s_req = im_req_o; s_addr = im_addr_o; s_valid = instr_valid_o;
    s_pc = pc_o; s_instr = instr_o; s_isc = is_compressed_instr_o;

    if (prev_hold) begin
      check("hold_valid", 32'(instr_valid_o), 32'd1);
      check("hold_pc", pc_o, prev_pc);
      check("hold_instr", instr_o, prev_instr);
    end

    if (im_req_o && im_gnt_i) begin
      check("req_addr_aligned", 32'(im_addr_o[1:0]), 32'd0);
      lat = (im_addr_o == slow_addr) ? slow_lat : $urandom_range(base_lat, max_lat);
      pend.push_back('{addr: im_addr_o, due: cyc + 1 + lat});
      check("outstanding_limit", 32'(pend.size() <= MAXO), 32'd1);
    end

    if (redir) begin
      exp_pc = rpc & ~32'h1;
    end else if (instr_valid_o && rdy) begin
      exp_i = instr_at(exp_pc);
      check("pc", pc_o, exp_pc);
      check("instr", instr_o, exp_i);
      check("is_c", 32'(is_compressed_instr_o), 32'(exp_i[1:0] != 2'b11));
      exp_pc = exp_pc + ((exp_i[1:0] == 2'b11) ? 32'd4 : 32'd2);
      n_consumed++;
    end

    prev_hold  = instr_valid_o && !rdy && !redir;
    prev_pc    = pc_o;
    prev_instr = instr_o;
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_i = 1'b0; instr_ready_i = 1'b0; im_gnt_i = 1'b0; im_rvalid_i = 1'b0;
    #1;
    check("rst_req", 32'(im_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_isc", 32'(is_compressed_instr_o), 32'd0);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_addr", im_addr_o, RESET_PC & ~32'h3);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    exp_pc = RESET_PC;
    prev_hold = 0;
    #1;
    check("post_rst_req", 32'(im_req_o), 32'd1);
    check("post_rst_addr", im_addr_o, RESET_PC & ~32'h3);
  endtask

  typedef struct {
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int k;
    int start_consumed;
    int nvalid;
    bit redir;
    logic [31:0] rpc;

    // 32-bit stream, single-cycle memory; decode stalls for cycles 6..10.
    tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0000_0000};
    tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'h0000_0013};
    tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h0004_0013};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0008_0013};
    tbl[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C, 32'h000C_0013};
    tbl[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10, 32'h0010_0013};
    tbl[7]  = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10, 32'h0010_0013};
    tbl[8]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h0010_0013};
    tbl[9]  = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h0010_0013};
    tbl[10] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h10, 32'h0010_0013};
    tbl[11] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h10, 32'h0010_0013};
    tbl[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 32'h0014_0013};

    mem_mode = 0;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rdy);
      check($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
      if (tbl[i].valid) check($sformatf("tbl%0d_instr", i), s_instr, tbl[i].instr);
    end

    // Two compressed instructions in one word.
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0001_4501;
    do_reset();
    cycle(1); cycle(1);
    cycle(1);
    check("c_pair0_valid", 32'(s_valid), 32'd1);
    check("c_pair0_instr", s_instr, 32'h0000_4501);
    check("c_pair0_pc", s_pc, 32'h0);
    check("c_pair0_isc", 32'(s_isc), 32'd1);
    cycle(1);
    check("c_pair1_valid", 32'(s_valid), 32'd1);
    check("c_pair1_instr", s_instr, 32'h0000_0001);
    check("c_pair1_pc", s_pc, 32'h2);
    check("c_pair1_isc", 32'(s_isc), 32'd1);
    cycle(1);
    check("c_pair_next_pc", s_pc, 32'h4);

    // 32-bit instruction at pc 2 spanning words 0 and 4, word 4 late.
    mem_ovr.delete();
    mem_ovr[32'h0] = 32'h0013_4501;
    mem_ovr[32'h4] = 32'h8082_0000;
    slow_addr = 32'h4;
    slow_lat  = 5;
    do_reset();
    cycle(1); cycle(1);
    cycle(1);
    check("span_c_pc", s_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1);
      check($sformatf("span_wait%0d_valid", i), 32'(s_valid), 32'd0);
    end
    cycle(1);
    check("span_valid", 32'(s_valid), 32'd1);
    check("span_instr", s_instr, 32'h0000_0013);
    check("span_pc", s_pc, 32'h2);
    check("span_isc", 32'(s_isc), 32'd0);
    slow_addr = 32'hFFFF_FFFF;
    mem_ovr.delete();

    // Redirect with two requests outstanding; bit 0 of the target ignored.
    mem_mode = 1;
    base_lat = 3;
    max_lat  = 3;
    do_reset();
    cycle(1); cycle(1);
    cycle(1, 1'b1, 32'h0000_0103);
    check("redir_req_low", 32'(s_req), 32'd0);
    cycle(1);
    check("redir_addr", s_addr, 32'h0000_0100);
    k = 0;
    while (!s_valid && k < 20) begin
      cycle(1);
      k++;
    end
    check("redir_first_in_time", 32'(k < 20), 32'd1);
    check("redir_first_pc", s_pc, 32'h0000_0102);
    check("redir_first_instr", s_instr, instr_at(32'h0000_0102));

    // Randomised traffic: random grants, latencies, stalls and redirects
    // (including targets near the top of the address space).
    rand_gnt = 1;
    base_lat = 0;
    max_lat  = 3;
    do_reset();
    start_consumed = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 99) < 3);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                          : ($urandom & 32'h0000_3FFF);
      cycle($urandom_range(0, 3) != 0, redir, rpc);
    end
    check("random_progress", 32'(n_consumed - start_consumed >= 300), 32'd1);

    // Reset in the middle of traffic, then full-throughput refetch.
    do_reset();
    rand_gnt = 0;
    max_lat  = 0;
    mem_mode = 0;
    nvalid   = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      if (i == 2) check("refetch_first_pc", s_pc, RESET_PC);
      if (i >= 2 && s_valid) nvalid++;
    end
    check("throughput_valid_cycles", nvalid, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (tests %0d, failed %0d)", n_tests, n_fail);
    $fatal(1);
  end

endmodule
